// File: rtl/mac_pkg.sv
// Shared constants and helpers for the systolic MAC tiles.
// Instruction bit positions, dataflow mode encodings and the signed-add overflow test.
package mac_pkg;

    localparam int INST_W     = 3;
    localparam int INST_LOAD  = 0;
    localparam int INST_EXEC  = 1;
    localparam int INST_FLUSH = 2;

    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;

    // Two operands of equal sign producing a sum of the other sign means the add wrapped.
    function automatic logic sum_ovf(input logic a_neg, input logic b_neg, input logic s_neg);
        return (a_neg == b_neg) && (s_neg != a_neg);
    endfunction

endpackage

// File: rtl/mac.sv
// Combinational signed multiply-accumulate: out = a*b + c, product sign-extended to psum_bw.
module mac #(
    parameter int bw      = 4,
    parameter int psum_bw = 16
) (
    input  logic signed [bw-1:0]      a,
    input  logic signed [bw-1:0]      b,
    input  logic signed [psum_bw-1:0] c,
    output logic signed [psum_bw-1:0] out
);

    logic signed [2*bw-1:0] prod;

    assign prod = a * b;
    assign out  = psum_bw'(prod) + c;

endmodule

// File: rtl/mac_tile_dual.sv
// Systolic processing element with run-time weight-stationary / output-stationary dataflow.
// One shared MAC serves both modes; its addend is c_q in WS and the local accumulator in OS.
module mac_tile_dual
    import mac_pkg::*;
#(
    parameter int bw      = 4,
    parameter int psum_bw = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [bw-1:0]        in_w,
    input  logic [INST_W-1:0]    inst_w,
    input  logic [psum_bw-1:0]   in_n,
    output logic [bw-1:0]        out_e,
    output logic [INST_W-1:0]    inst_e,
    output logic [psum_bw-1:0]   out_s,
    output logic                 out_s_vld,
    output logic                 ovf
);

    logic signed [bw-1:0]      a_q;
    logic signed [bw-1:0]      b_q;
    logic signed [psum_bw-1:0] c_q;
    logic signed [psum_bw-1:0] acc_q;
    logic signed [psum_bw-1:0] drain_q;
    logic [INST_W-1:0]         inst_q;
    logic                      mode_q;
    logic                      vld_q;
    logic                      ovf_q;
    logic                      load_rdy_q;
    logic                      drain_rdy_q;

    logic signed [psum_bw-1:0] mac_c;
    logic signed [psum_bw-1:0] mac_out;
    logic                      prod_neg;
    logic                      acc_ovf;
    logic                      load;
    logic                      exec;
    logic                      flush;
    logic                      idle;

    assign load  = inst_w[INST_LOAD];
    assign exec  = inst_w[INST_EXEC];
    assign flush = inst_w[INST_FLUSH];
    assign idle  = (inst_w == '0);

    assign mac_c = (mode_q == MODE_OS) ? acc_q : c_q;

    mac #(
        .bw      (bw),
        .psum_bw (psum_bw)
    ) u_mac (
        .a   (a_q),
        .b   (b_q),
        .c   (mac_c),
        .out (mac_out)
    );

    // A zero product counts as non-negative, so it can never trip the overflow test.
    assign prod_neg = (a_q != '0) && (b_q != '0) && (a_q[bw-1] ^ b_q[bw-1]);
    assign acc_ovf  = sum_ovf(acc_q[psum_bw-1], prod_neg, mac_out[psum_bw-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            acc_q       <= '0;
            drain_q     <= '0;
            inst_q      <= '0;
            mode_q      <= MODE_WS;
            vld_q       <= 1'b0;
            ovf_q       <= 1'b0;
            load_rdy_q  <= 1'b1;
            drain_rdy_q <= 1'b1;
        end else begin
            inst_q[INST_EXEC]  <= exec;
            inst_q[INST_FLUSH] <= flush;
            inst_q[INST_LOAD]  <= 1'b0;
            vld_q              <= 1'b0;

            if (mode_q == MODE_WS) begin
                if (load || exec) begin
                    a_q <= in_w;
                    c_q <= in_n;
                end
                // The first load keeps the weight here; later ones are passed east.
                if (load) begin
                    if (load_rdy_q) begin
                        b_q        <= in_w;
                        load_rdy_q <= 1'b0;
                    end else begin
                        inst_q[INST_LOAD] <= 1'b1;
                    end
                end
            end else begin
                vld_q <= flush;
                // Operands are cleared outside execute so the next burst starts by adding 0.
                if (exec && !flush) begin
                    a_q <= in_w;
                    b_q <= in_n[bw-1:0];
                end else begin
                    a_q <= '0;
                    b_q <= '0;
                end
                if (flush) begin
                    if (drain_rdy_q) begin
                        drain_q     <= mac_out;
                        acc_q       <= '0;
                        drain_rdy_q <= 1'b0;
                        if (acc_ovf) ovf_q <= 1'b1;
                    end else begin
                        drain_q <= in_n;
                    end
                end else if (exec) begin
                    acc_q <= mac_out;
                    if (acc_ovf) ovf_q <= 1'b1;
                end
            end

            if (idle) begin
                mode_q <= mode;
                if (mode != mode_q) begin
                    load_rdy_q  <= 1'b1;
                    drain_rdy_q <= 1'b1;
                    ovf_q       <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        out_s = mac_out;
        if (mode_q == MODE_OS) begin
            out_s = vld_q ? drain_q : psum_bw'(b_q);
        end
    end

    assign out_e     = a_q;
    assign inst_e    = inst_q;
    assign out_s_vld = vld_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_tile_dual.sv
// Bench for mac_tile_dual: directed vector table, an 8-bit overflow sequence and
// randomized WS/OS traffic checked against plain integer arithmetic.
module tb_mac_tile_dual;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 16-bit accumulator instance
    logic        r0, m0, vld0, ovf0;
    logic [3:0]  w0, e0;
    logic [2:0]  i0, ie0;
    logic [15:0] n0, s0;

    // 8-bit accumulator instance for the wrap/overflow case
    logic        r1, m1, vld1, ovf1;
    logic [3:0]  w1, e1;
    logic [2:0]  i1, ie1;
    logic [7:0]  n1, s1;

    int total = 0;
    int bad   = 0;

    mac_tile_dual #(.bw(4), .psum_bw(16)) u0 (
        .clk(clk), .reset(r0), .mode(m0), .in_w(w0), .inst_w(i0), .in_n(n0),
        .out_e(e0), .inst_e(ie0), .out_s(s0), .out_s_vld(vld0), .ovf(ovf0)
    );

    mac_tile_dual #(.bw(4), .psum_bw(8)) u1 (
        .clk(clk), .reset(r1), .mode(m1), .in_w(w1), .inst_w(i1), .in_n(n1),
        .out_e(e1), .inst_e(ie1), .out_s(s1), .out_s_vld(vld1), .ovf(ovf1)
    );

    typedef struct {
        logic              rst;
        logic              mode;
        logic [2:0]        inst;
        logic signed [3:0] in_w;
        logic [15:0]       in_n;
        logic signed [15:0] exp_s;
        logic              exp_vld;
        logic [3:0]        exp_e;
        logic [2:0]        exp_ie;
        logic              exp_ovf;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t v(input logic rst, input logic mode, input logic [2:0] inst,
                               input int w, input int n, input int s, input logic vld,
                               input int e, input logic [2:0] ie, input logic ov);
        vec_t r;
        r.rst = rst; r.mode = mode; r.inst = inst;
        r.in_w = 4'(w); r.in_n = 16'(n); r.exp_s = 16'(s);
        r.exp_vld = vld; r.exp_e = 4'(e); r.exp_ie = ie; r.exp_ovf = ov;
        return r;
    endfunction

    function automatic int s4(input int x);
        logic signed [3:0] t;
        t = x[3:0];
        return int'(t);
    endfunction

    function automatic int wrap16(input int x);
        logic signed [15:0] t;
        t = x[15:0];
        return int'(t);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic rst, input logic mode, input logic [2:0] inst,
                          input int w, input int n);
        r0 = rst; m0 = mode; i0 = inst; w0 = 4'(w); n0 = 16'(n);
    endtask

    task automatic drive1(input logic rst, input logic mode, input logic [2:0] inst,
                          input int w, input int n);
        r1 = rst; m1 = mode; i1 = inst; w1 = 4'(w); n1 = 8'(n);
    endtask

    initial begin
        int k, w, n, nw, x, sum, wt;

        drive0(1, 0, 3'b000, 0, 0);
        drive1(1, 0, 3'b000, 0, 0);

        //            rst mode inst    in_w in_n  out_s vld out_e inst_e ovf
        vecs[0]  = v(1, 0, 3'b000,  0,   0,     0, 0,  0, 3'b000, 0); // reset
        vecs[1]  = v(0, 0, 3'b001,  3,   0,     9, 0,  3, 3'b000, 0); // first load keeps weight
        vecs[2]  = v(0, 0, 3'b001,  3,   0,     9, 0,  3, 3'b001, 0); // second load goes east
        vecs[3]  = v(0, 0, 3'b010, -2,  10,     4, 0, -2, 3'b010, 0); // -2*3+10
        vecs[4]  = v(0, 1, 3'b010,  1,   5,     8, 0,  1, 3'b010, 0); // mode ignored while busy
        vecs[5]  = v(0, 1, 3'b000,  0,   0,     3, 0,  1, 3'b000, 0); // idle: now OS, b forwarded
        vecs[6]  = v(0, 0, 3'b000,  0,   0,     5, 0,  0, 3'b000, 0); // back to WS, operands cleared
        vecs[7]  = v(0, 0, 3'b001,  5,   0,    25, 0,  5, 3'b000, 0); // re-armed load takes new weight
        vecs[8]  = v(0, 0, 3'b010,  2,   1,    11, 0,  2, 3'b010, 0); // 2*5+1
        vecs[9]  = v(0, 1, 3'b000,  0,   0,     5, 0,  2, 3'b000, 0); // to OS
        vecs[10] = v(0, 1, 3'b000,  0,   0,     0, 0,  0, 3'b000, 0); // OS idle clears operands
        vecs[11] = v(0, 1, 3'b010,  2,   3,     3, 0,  2, 3'b010, 0);
        vecs[12] = v(0, 1, 3'b010, -1,   4,     4, 0, -1, 3'b010, 0);
        vecs[13] = v(0, 1, 3'b010,  7,  -1,    -1, 0,  7, 3'b010, 0);
        vecs[14] = v(0, 1, 3'b100,  0,   0,    -5, 1,  0, 3'b100, 0); // 6-4-7
        vecs[15] = v(0, 1, 3'b000,  0,   0,     0, 0,  0, 3'b000, 0);
        vecs[16] = v(0, 0, 3'b000,  0,   0,     1, 0,  0, 3'b000, 0); // to WS: out = c_q (1)
        vecs[17] = v(0, 1, 3'b000,  0,   0,     0, 0,  0, 3'b000, 0); // to OS, drain re-armed
        vecs[18] = v(0, 1, 3'b100,  0,   0,     0, 1,  0, 3'b100, 0); // own result: acc was cleared
        vecs[19] = v(0, 1, 3'b100,  0, 100,   100, 1,  0, 3'b100, 0);
        vecs[20] = v(0, 1, 3'b100,  0, 200,   200, 1,  0, 3'b100, 0);
        vecs[21] = v(0, 1, 3'b000,  0,   0,     0, 0,  0, 3'b000, 0);
        vecs[22] = v(0, 1, 3'b010,  3,   3,     3, 0,  3, 3'b010, 0);
        vecs[23] = v(0, 1, 3'b100,  0,  77,    77, 1,  0, 3'b100, 0); // drain not re-armed: shifts in_n
        vecs[24] = v(1, 1, 3'b100,  0,  55,     0, 0,  0, 3'b000, 0); // reset mid-flush

        for (int i = 0; i < 25; i++) begin
            drive0(vecs[i].rst, vecs[i].mode, vecs[i].inst, int'(vecs[i].in_w), int'(vecs[i].in_n));
            step();
            $display("vec %0d: rst=%b mode=%b inst=%b in_w=%0d in_n=%0d -> out_s=%0d vld=%b out_e=%0d inst_e=%b ovf=%b",
                     i, r0, m0, i0, $signed(w0), $signed(n0), $signed(s0), vld0, $signed(e0), ie0, ovf0);
            chk($sformatf("vec%0d out_s", i), int'($signed(s0)), int'(vecs[i].exp_s));
            chk($sformatf("vec%0d out_s_vld", i), int'(vld0), int'(vecs[i].exp_vld));
            chk($sformatf("vec%0d out_e", i), int'(e0), int'(vecs[i].exp_e));
            chk($sformatf("vec%0d inst_e", i), int'(ie0), int'(vecs[i].exp_ie));
            chk($sformatf("vec%0d ovf", i), int'(ovf0), int'(vecs[i].exp_ovf));
        end

        // 8-bit accumulator: 3 x (7*7) = 147 wraps to -109 and sets ovf
        drive1(1, 0, 3'b000, 0, 0); step();
        drive1(0, 1, 3'b000, 0, 0); step();
        for (int j = 0; j < 3; j++) begin
            drive1(0, 1, 3'b010, 7, 7); step();
            $display("ovf exec %0d: out_s=%0d ovf=%b", j, $signed(s1), ovf1);
        end
        chk("ovf8 before wrap", int'(ovf1), 0);
        drive1(0, 1, 3'b100, 0, 0); step();
        $display("ovf flush: out_s=%0d vld=%b ovf=%b", $signed(s1), vld1, ovf1);
        chk("ovf8 drain value", int'($signed(s1)), -109);
        chk("ovf8 drain vld", int'(vld1), 1);
        chk("ovf8 flag set", int'(ovf1), 1);
        drive1(0, 1, 3'b000, 0, 0); step();
        $display("ovf idle: ovf=%b", ovf1);
        chk("ovf8 sticky", int'(ovf1), 1);
        drive1(0, 0, 3'b000, 0, 0); step();
        $display("ovf mode change: ovf=%b", ovf1);
        chk("ovf8 cleared by mode change", int'(ovf1), 0);

        // Randomized OS bursts: drained value is the wrapped sum of all products in the burst
        drive0(1, 0, 3'b000, 0, 0); step();
        drive0(0, 1, 3'b000, 0, 0); step();
        for (int b = 0; b < 20; b++) begin
            k = int'($urandom_range(1, 8));
            sum = 0;
            for (int j = 0; j < k; j++) begin
                w  = int'($urandom_range(0, 15));
                n  = int'($urandom_range(0, 65535));
                nw = s4(n);
                sum += s4(w) * nw;
                drive0(0, 1, 3'b010, w, n); step();
                $display("os burst %0d exec %0d: in_w=%0d w=%0d -> out_s=%0d out_e=%0d", b, j, s4(w), nw, $signed(s0), $signed(e0));
                chk("os fwd weight", int'($signed(s0)), nw);
                chk("os out_e", int'(e0), w);
                chk("os inst_e", int'(ie0), 2);
            end
            drive0(0, 1, 3'b100, 0, 0); step();
            $display("os burst %0d flush: out_s=%0d expected %0d vld=%b", b, $signed(s0), wrap16(sum), vld0);
            chk("os drain sum", int'($signed(s0)), wrap16(sum));
            chk("os drain vld", int'(vld0), 1);
            chk("os ovf", int'(ovf0), 0);
            drive0(0, 0, 3'b000, 0, 0); step();
            drive0(0, 1, 3'b000, 0, 0); step();
        end

        // Randomized WS: out_s = in_w * weight + in_n, one cycle later
        drive0(0, 0, 3'b000, 0, 0); step();
        wt = int'($urandom_range(0, 15));
        drive0(0, 0, 3'b001, wt, 0); step();
        for (int j = 0; j < 30; j++) begin
            x = int'($urandom_range(0, 15));
            n = int'($urandom_range(0, 65535));
            drive0(0, 0, 3'b010, x, n); step();
            $display("ws exec %0d: in_w=%0d wt=%0d in_n=%0d -> out_s=%0d", j, s4(x), s4(wt), wrap16(n), $signed(s0));
            chk("ws mac", int'($signed(s0)), wrap16(s4(x) * s4(wt) + wrap16(n)));
            chk("ws out_e", int'(e0), x);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
